// File: rtl/mem_credit_arb.sv
// mem_credit_arb
// ----------------------------------------------------------------------------
// Multi-port credit manager and round-robin arbiter for one shared
// memory-network injection channel. Each of NPORT ports has a pool of
// MAXCREDIT credits. At most one request is granted per cycle, and only to a
// port that still holds credit. Credits come back through a single return
// channel. Protocol violations raise a sticky error flag.
//
// Ports:
//   gclk, rstn     clock; asynchronous active-low reset
//   req_valid      per-port request pending (held until granted)
//   gnt            registered one-hot grant
//   gnt_valid      a grant is being presented this cycle
//   gnt_port       encoded index of the granted port (0 when idle)
//   net_ready      network accepts an injection this cycle
//   ret_valid      credit return strobe
//   ret_port       port whose credit is returned
//   credit_empty   per-port counter == 0 (registered, post-update)
//   credit_full    per-port counter == MAXCREDIT (registered, post-update)
//   err            sticky protocol error (overflowing return or bad port)
//   err_port       port that caused the first error
//   stall_cnt      per-port 16-bit saturating stall counters
//                  (present only when MEM_CREDIT_STATS_EN is defined)
//
// Optional build macro: MEM_CREDIT_STATS_EN
// ----------------------------------------------------------------------------
module mem_credit_arb #(
  parameter int NPORT     = 4,
  parameter int MAXCREDIT = 64,
  parameter int CNTW      = $clog2(MAXCREDIT) + 1,
  parameter int PIDW      = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic             gclk,
  input  logic             rstn,
  input  logic [NPORT-1:0] req_valid,
  output logic [NPORT-1:0] gnt,
  output logic             gnt_valid,
  output logic [PIDW-1:0]  gnt_port,
  input  logic             net_ready,
  input  logic             ret_valid,
  input  logic [PIDW-1:0]  ret_port,
  output logic [NPORT-1:0] credit_empty,
  output logic [NPORT-1:0] credit_full,
  output logic             err,
  output logic [PIDW-1:0]  err_port
`ifdef MEM_CREDIT_STATS_EN
  ,
  output logic [NPORT-1:0][15:0] stall_cnt
`endif
);

  localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(MAXCREDIT);
  localparam logic [CNTW-1:0] CNT_ZERO  = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1'b1);
  localparam logic [PIDW:0]   NPORT_W   = (PIDW+1)'(NPORT);
  localparam logic [PIDW-1:0] LAST_PORT = PIDW'(NPORT - 1);
  localparam logic [PIDW-1:0] PID_ZERO  = {PIDW{1'b0}};
  localparam logic [PIDW-1:0] PID_ONE   = PIDW'(1'b1);

  // State registers and next-state values
  logic [CNTW-1:0]  cnt_q [NPORT];
  logic [CNTW-1:0]  cnt_d [NPORT];
  logic [PIDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NPORT-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [PIDW-1:0]  gnt_port_q, gnt_port_d;
  logic [NPORT-1:0] empty_q, empty_d;
  logic [NPORT-1:0] full_q, full_d;
  logic             err_q, err_d;
  logic [PIDW-1:0]  err_port_q, err_port_d;

  // Combinational helpers
  logic [NPORT-1:0] elig_s;
  logic [PIDW:0]    scan_idx_s;
  logic             win_found_s;
  logic [PIDW-1:0]  win_idx_s;
  logic             grant_s;
  logic [NPORT-1:0] dec_s;
  logic [NPORT-1:0] inc_s;
  logic             ret_ok_s;
  logic             ret_at_max_s;
  logic             ret_err_s;

  // Eligibility uses the pre-update count, so a return arriving in the same
  // cycle as a request on an empty port does not produce a grant until the
  // following cycle.
  always_comb begin
    elig_s = {NPORT{1'b0}};
    for (int i = 0; i < NPORT; i++) begin
      elig_s[i] = req_valid[i] & (cnt_q[i] != CNT_ZERO);
    end
  end

  // Round-robin search: start at rr_ptr_q, wrap modulo NPORT, first eligible wins
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = PID_ZERO;
    scan_idx_s  = {(PIDW+1){1'b0}};
    for (int k = 0; k < NPORT; k++) begin
      // rr_ptr_q < NPORT and k < NPORT, so a single subtraction wraps correctly
      scan_idx_s  = {1'b0, rr_ptr_q} + (PIDW+1)'(k);
      scan_idx_s  = (scan_idx_s >= NPORT_W) ? (scan_idx_s - NPORT_W) : scan_idx_s;
      win_idx_s   = (!win_found_s && elig_s[scan_idx_s[PIDW-1:0]]) ?
                    scan_idx_s[PIDW-1:0] : win_idx_s;
      win_found_s = win_found_s | elig_s[scan_idx_s[PIDW-1:0]];
    end
    grant_s = net_ready & win_found_s;
  end

  // Per-port credit counter update and the post-update empty/full flags
  always_comb begin
    ret_ok_s     = ({1'b0, ret_port} < NPORT_W);
    ret_at_max_s = 1'b0;
    dec_s        = {NPORT{1'b0}};
    inc_s        = {NPORT{1'b0}};
    empty_d      = {NPORT{1'b0}};
    full_d       = {NPORT{1'b0}};
    for (int i = 0; i < NPORT; i++) begin
      cnt_d[i]     = cnt_q[i];
      dec_s[i]     = grant_s & (win_idx_s == PIDW'(i));
      inc_s[i]     = ret_valid & (ret_port == PIDW'(i));
      ret_at_max_s = ret_at_max_s | (inc_s[i] & (cnt_q[i] == CNT_MAX));
      case ({dec_s[i], inc_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] - CNT_ONE;
        // a return with nothing outstanding saturates; the error is raised below
        2'b01:   cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : (cnt_q[i] + CNT_ONE);
        default: cnt_d[i] = cnt_q[i];
      endcase
      empty_d[i] = (cnt_d[i] == CNT_ZERO);
      full_d[i]  = (cnt_d[i] == CNT_MAX);
    end
  end

  // Grant outputs, round-robin pointer and sticky error next state
  always_comb begin
    gnt_d       = {NPORT{1'b0}};
    gnt_valid_d = grant_s;
    gnt_port_d  = PID_ZERO;
    rr_ptr_d    = rr_ptr_q;
    if (grant_s) begin
      gnt_d[win_idx_s] = 1'b1;
      gnt_port_d       = win_idx_s;
      rr_ptr_d         = (win_idx_s == LAST_PORT) ? PID_ZERO : (win_idx_s + PID_ONE);
    end else begin
      gnt_d      = {NPORT{1'b0}};
      gnt_port_d = PID_ZERO;
      rr_ptr_d   = rr_ptr_q;
    end

    ret_err_s  = ret_valid & (~ret_ok_s | ret_at_max_s);
    err_d      = err_q | ret_err_s;
    err_port_d = err_port_q;
    // only the first offending port is recorded
    if (ret_err_s && !err_q) begin
      err_port_d = ret_port;
    end else begin
      err_port_d = err_port_q;
    end
  end

  // State registers with asynchronous reset to the full-credit idle state
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NPORT; i++) begin
        cnt_q[i] <= CNT_MAX;
      end
      rr_ptr_q    <= PID_ZERO;
      gnt_q       <= {NPORT{1'b0}};
      gnt_valid_q <= 1'b0;
      gnt_port_q  <= PID_ZERO;
      empty_q     <= {NPORT{1'b0}};
      full_q      <= {NPORT{1'b1}};
      err_q       <= 1'b0;
      err_port_q  <= PID_ZERO;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_port_q  <= gnt_port_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      err_q       <= err_d;
      err_port_q  <= err_port_d;
    end
  end

  assign gnt          = gnt_q;
  assign gnt_valid    = gnt_valid_q;
  assign gnt_port     = gnt_port_q;
  assign credit_empty = empty_q;
  assign credit_full  = full_q;
  assign err          = err_q;
  assign err_port     = err_port_q;

`ifdef MEM_CREDIT_STATS_EN
  logic [NPORT-1:0][15:0] stall_q, stall_d;

  // Stall counters: a pending request that is not granted because the port
  // has no credit or another port won the arbitration
  always_comb begin
    stall_d = stall_q;
    for (int i = 0; i < NPORT; i++) begin
      if (req_valid[i] && !dec_s[i] && ((cnt_q[i] == CNT_ZERO) || grant_s)) begin
        stall_d[i] = (stall_q[i] == 16'hFFFF) ? stall_q[i] : (stall_q[i] + 16'd1);
      end else begin
        stall_d[i] = stall_q[i];
      end
    end
  end

  // Stall counter registers, cleared only by reset
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= {(NPORT*16){1'b0}};
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
